// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int         MAX_REQ  = 16;
    localparam logic [7:0] HDR_BASE = 8'hA0;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping at NUM_REQ, returned as one-hot plus encoded index.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] one_hot,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    int cand;

    always_comb begin
        one_hot = '0;
        index   = '0;
        any     = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Explicit wrap so non-power-of-two NUM_REQ never aliases.
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && req_valid[cand]) begin
                any           = 1'b1;
                index         = IDX_W'(cand);
                one_hot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uartTX between NUM_REQ packet streams.
// Define UART_ARB_HEADER_EN to prefix every packet with HDR_BASE | index.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 active,
    output arb_state_t           state_dbg,
    output logic [IDX_W-1:0]     ptr_dbg
);

    // Handshakes: a requester byte moves when req_valid[i] && req_ready[i]
    // at a rising edge; ready is only ever offered to the granted index in
    // LOAD. Each byte to uartTX is one tx_send pulse, and the next pulse
    // waits for tx_busy to rise and then fall.

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_next;
    logic [7:0]           tx_data_q;
    logic                 last_q;
    logic                 active_q;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic                 cur_valid;
    logic [7:0]           cur_data;
    logic                 cur_last;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .one_hot   (pick_grant),
        .index     (pick_idx),
        .any       (pick_any)
    );

    assign cur_valid = req_valid[idx_q];
    assign cur_data  = req_data[{idx_q, 3'b000} +: 8];
    assign cur_last  = req_last[idx_q];
    assign ptr_next  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        tx_send   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
`ifdef UART_ARB_HEADER_EN
                    state_d = HDR;
`else
                    state_d = LOAD;
`endif
                end
            end
`ifdef UART_ARB_HEADER_EN
            HDR: state_d = SEND;
`endif
            LOAD: begin
                req_ready = grant_q & req_valid;
                if (cur_valid) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_send = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = last_q ? IDLE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            tx_data_q <= 8'h00;
            last_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q  <= pick_grant;
                        idx_q    <= pick_idx;
                        active_q <= 1'b1;
                    end
                end
`ifdef UART_ARB_HEADER_EN
                HDR: begin
                    tx_data_q <= HDR_BASE | 8'(idx_q);
                    last_q    <= 1'b0;
                end
`endif
                LOAD: begin
                    if (cur_valid) begin
                        tx_data_q <= cur_data;
                        last_q    <= cur_last;
                    end
                end
                WAIT_DONE: begin
                    // Release only once the final frame has fully left the UART.
                    if (!tx_busy && last_q) begin
                        grant_q  <= '0;
                        active_q <= 1'b0;
                        ptr_q    <= ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign active    = active_q;
    assign state_dbg = state_q;
    assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uartTX busy model and
// per-requester packet sources; honours UART_ARB_HEADER_EN when defined.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N     = 4;
    localparam int FRAME = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_send;
    logic             tx_busy;
    logic [N-1:0]     grant;
    logic             active;
    arb_state_t       state_dbg;
    logic [1:0]       ptr_dbg;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .active    (active),
        .state_dbg (state_dbg),
        .ptr_dbg   (ptr_dbg)
    );

    // uartTX model: busy from the cycle after tx_send for FRAME cycles.
    int         busy_cnt;
    int         proto_err = 0;
    int         stable_err = 0;
    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_send) begin
            if (tx_busy) proto_err <= proto_err + 1;
            tx_busy  <= 1'b1;
            busy_cnt <= FRAME;
            frame_q.push_back(tx_data);
        end else begin
            if (tx_busy && frame_q.size() > 0 && tx_data !== frame_q[$])
                stable_err <= stable_err + 1;
            if (busy_cnt > 1) begin
                busy_cnt <= busy_cnt - 1;
            end else begin
                busy_cnt <= 0;
                tx_busy  <= 1'b0;
            end
        end
    end

    // Packet sources
    logic [7:0] src_data[N][4];
    int         src_len[N];
    int         src_pos[N];
    logic [N-1:0] mask;
    logic [N-1:0] hs_pending;

    int total = 0;
    int passed = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [1:0] exp_ptr;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i] && mask[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = src_data[i][src_pos[i]];
                req_last[i]        = (src_pos[i] == src_len[i] - 1);
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic settle();
        drive();
        #1;
        hs_pending = req_valid & req_ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs_pending[i]) src_pos[i]++;
        settle();
    endtask

    task automatic add_pkt(input int idx, input int len, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input bit to_exp);
        src_data[idx][0] = b0;
        src_data[idx][1] = b1;
        src_data[idx][2] = b2;
        src_len[idx] = len;
        src_pos[idx] = 0;
        if (to_exp) begin
`ifdef UART_ARB_HEADER_EN
            exp_q.push_back(HDR_BASE | 8'(idx));
`endif
            exp_q.push_back(b0);
            if (len > 1) exp_q.push_back(b1);
            if (len > 2) exp_q.push_back(b2);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        mask = '1;
        frame_q.delete();
        exp_q.delete();
        hs_pending = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_all();
        drive();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 hs_pending = '0;
    endtask

    function automatic bit drained();
        for (int i = 0; i < N; i++)
            if (src_pos[i] < src_len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(active == 1'b0 && !tx_busy && drained()) && n < 500) begin
            step();
            n++;
        end
        check({name, "_timeout"}, (n < 500), 1);
    endtask

    task automatic check_frames(input string name);
        check({name, "_count"}, frame_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < frame_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), frame_q[i], exp_q[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        reset     = 1'b0;
        vecs[0] = '{idx: 1, data: 8'h55, exp_ptr: 2'd2};
        vecs[1] = '{idx: 3, data: 8'hC3, exp_ptr: 2'd0};
        vecs[2] = '{idx: 0, data: 8'h01, exp_ptr: 2'd1};
        vecs[3] = '{idx: 2, data: 8'hFE, exp_ptr: 2'd3};

        apply_reset();
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_send", tx_send, 0);
        check("rst_grant", grant, 0);
        check("rst_active", active, 0);
        check("rst_ptr", ptr_dbg, 0);
        check("rst_state", state_dbg, IDLE);

        // Single-byte packets: latency, one-cycle pulse, release and ptr advance.
        for (int v = 0; v < 4; v++) begin
            add_pkt(vecs[v].idx, 1, vecs[v].data, 8'h00, 8'h00, 1'b1);
            settle();
            step();
            check($sformatf("v%0d_grant", v), grant, 32'(1) << vecs[v].idx);
            check($sformatf("v%0d_active", v), active, 1);
`ifdef UART_ARB_HEADER_EN
            check($sformatf("v%0d_ready", v), req_ready, 0);
`else
            check($sformatf("v%0d_ready", v), req_ready, 32'(1) << vecs[v].idx);
`endif
            step();
            check($sformatf("v%0d_send", v), tx_send, 1);
`ifdef UART_ARB_HEADER_EN
            check($sformatf("v%0d_data", v), tx_data, HDR_BASE | 8'(vecs[v].idx));
`else
            check($sformatf("v%0d_data", v), tx_data, vecs[v].data);
`endif
            step();
            check($sformatf("v%0d_pulse", v), tx_send, 0);
            wait_idle($sformatf("v%0d_idle", v));
            check($sformatf("v%0d_release", v), grant, 0);
            check($sformatf("v%0d_ptr", v), ptr_dbg, vecs[v].exp_ptr);
        end
        check_frames("single");

        // Two simultaneous 2-byte packets: no interleaving.
        apply_reset();
        add_pkt(0, 2, 8'h10, 8'h11, 8'h00, 1'b1);
        add_pkt(2, 2, 8'h20, 8'h21, 8'h00, 1'b1);
        settle();
        step();
        check("dual_first_grant", grant, 4'b0001);
        wait_idle("dual_idle");
        check("dual_ptr", ptr_dbg, 3);
        check_frames("dual");

        // Pointer wrap after requester 3.
        apply_reset();
        add_pkt(3, 1, 8'h33, 8'h00, 8'h00, 1'b1);
        settle();
        wait_idle("wrap_a_idle");
        check("wrap_ptr", ptr_dbg, 0);
        add_pkt(0, 1, 8'h40, 8'h00, 8'h00, 1'b1);
        add_pkt(3, 1, 8'h43, 8'h00, 8'h00, 1'b1);
        settle();
        step();
        check("wrap_grant", grant, 4'b0001);
        wait_idle("wrap_b_idle");
        check_frames("wrap");

        // Granted requester stalls mid-packet; grant is held, no preemption.
        apply_reset();
        add_pkt(0, 3, 8'h50, 8'h51, 8'h52, 1'b1);
        settle();
        n = 0;
        while (src_pos[0] < 1 && n < 100) begin
            step();
            n++;
        end
        check("stall_first_byte", (n < 100), 1);
        mask[0] = 1'b0;
        add_pkt(1, 1, 8'h61, 8'h00, 8'h00, 1'b1);
        settle();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (grant !== 4'b0001 || req_ready[1] !== 1'b0) bad++;
        end
        check("stall_hold", bad, 0);
        check("stall_state", state_dbg, LOAD);
        mask[0] = 1'b1;
        settle();
        wait_idle("stall_idle");
        check_frames("stall");

        // Reset during WAIT_DONE aborts; next grant searches from ptr 0.
        apply_reset();
        add_pkt(2, 1, 8'h2A, 8'h00, 8'h00, 1'b1);
        settle();
        wait_idle("abort_pre_idle");
        check("abort_pre_ptr", ptr_dbg, 3);
        add_pkt(1, 2, 8'h71, 8'h72, 8'h00, 1'b0);
        settle();
        n = 0;
        while (state_dbg != WAIT_DONE && n < 100) begin
            step();
            n++;
        end
        check("abort_reach_wait_done", (n < 100), 1);
        reset = 1'b1;
        #1;
        check("abort_tx_send", tx_send, 0);
        check("abort_grant", grant, 0);
        check("abort_active", active, 0);
        check("abort_tx_data", tx_data, 0);
        check("abort_ready", req_ready, 0);
        check("abort_ptr", ptr_dbg, 0);
        check("abort_state", state_dbg, IDLE);
        clear_all();
        drive();
        @(posedge clk);
        #1 reset = 1'b0;
        add_pkt(1, 1, 8'h81, 8'h00, 8'h00, 1'b1);
        add_pkt(3, 1, 8'h83, 8'h00, 8'h00, 1'b1);
        settle();
        step();
        check("abort_new_grant", grant, 4'b0010);
        wait_idle("abort_post_idle");
        check_frames("abort");

        check("proto_send_while_busy", proto_err, 0);
        check("tx_data_stable", stable_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
